// File: rtl/blink_rate_monitor_if.sv
// Bundle between a toggling heartbeat source and the blink-rate monitor.
// The source drives sig_in; the monitor reports measurement and status back.
interface blink_rate_monitor_if #(
  parameter int CNT_W = 26
);
  logic             sig_in;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             in_tol;
  logic             locked;
  logic             stuck;

  modport master (
    output sig_in,
    input  half_period, meas_valid, in_tol, locked, stuck
  );

  modport slave (
    input  sig_in,
    output half_period, meas_valid, in_tol, locked, stuck
  );
endinterface

// File: rtl/blink_rate_monitor.sv
// Measures half-periods of an asynchronous toggling input, checks each one against
// EXP_HALF +/- TOL, and reports lock (LOCK_N good in a row) and stuck (no edge) status.
module blink_rate_monitor #(
  parameter int EXP_HALF = 25_000_000,
  parameter int TOL      = 250_000,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  blink_rate_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] LO  = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam int               GW  = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0]    GMAX = GW'(LOCK_N);

  typedef enum logic [1:0] {WAIT, ACQ, LOCK} state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             sig_edge;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ok;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             mv_q, mv_d;
  logic             tol_q, tol_d;
  logic             lk_q, lk_d;
  logic             stk_q, stk_d;

  // Two-flop synchroniser plus one delay stage; either polarity is an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge = s2 ^ s3;

  // Interval counter: reads N on the edge cycle N cycles after the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (sig_edge)   cnt <= CNT_W'(1);
    else if (cnt != TMO) cnt <= cnt + 1'b1;
  end

  assign cnt_ok   = (cnt >= LO) && (cnt <= HI);
  assign good_inc = (good_q == GMAX) ? GMAX : good_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      good_q  <= '0;
      hp_q    <= '0;
      mv_q    <= 1'b0;
      tol_q   <= 1'b0;
      lk_q    <= 1'b0;
      stk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      hp_q    <= hp_d;
      mv_q    <= mv_d;
      tol_q   <= tol_d;
      lk_q    <= lk_d;
      stk_q   <= stk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    hp_d    = hp_q;
    mv_d    = 1'b0;
    tol_d   = tol_q;
    lk_d    = lk_q;
    stk_d   = stk_q;
    case (state_q)
      WAIT: begin
        // First edge only establishes a reference; the partial interval is dropped.
        if (sig_edge) begin
          state_d = ACQ;
          stk_d   = 1'b0;
        end
      end
      ACQ, LOCK: begin
        if (sig_edge) begin
          // An edge landing on the timeout cycle still measures (and fails tolerance).
          hp_d  = cnt;
          mv_d  = 1'b1;
          tol_d = cnt_ok;
          if (cnt_ok) begin
            good_d = good_inc;
            if (good_inc == GMAX) begin
              state_d = LOCK;
              lk_d    = 1'b1;
            end
          end else begin
            good_d  = '0;
            state_d = ACQ;
            lk_d    = 1'b0;
          end
        end else if (cnt == TMO) begin
          stk_d   = 1'b1;
          lk_d    = 1'b0;
          good_d  = '0;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  assign mon.half_period = hp_q;
  assign mon.meas_valid  = mv_q;
  assign mon.in_tol      = tol_q;
  assign mon.locked      = lk_q;
  assign mon.stuck       = stk_q;

endmodule
